exe_stage: RTL and testbench

- Consumer end of the decode-stage output bundle.
- Latches the decoded control word, operands and immediates into an internal ID/EXE register.
- Computes the shifter operand (Val2), the ALU result and the branch target.
- Owns the NZCV status register that feeds back to decode's condition check, and drives the branch-taken/flush signal back to fetch/decode.

---
 rtl/exe_stage_pkg.sv | 66 ++++++
 rtl/exe_stage_val2_gen.sv | 49 ++++
 rtl/exe_stage.sv | 157 +++++++++++++++
 tb/tb_exe_stage.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU op encodings, shift types,
// NZCV bit positions and the ID/EXE register layout with its bubble value.
package exe_stage_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned IMM8_W = 8;
    localparam int unsigned ROT_W  = 4;
    localparam int unsigned SIMM_W = 24;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned NZCV_W = 4;

    // NZCV bit indices inside the 4-bit flag vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'b0000,
        CMD_MOV = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_ADC = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SBC = 4'b0101,
        CMD_AND = 4'b0110,
        CMD_ORR = 4'b0111,
        CMD_EOR = 4'b1000,
        CMD_MVN = 4'b1001
    } exe_cmd_e;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_e;

    typedef struct packed {
        logic wb_en;
        logic mem_read;
        logic mem_write;
        logic s;
        logic b;
        logic is_imm;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // flag_pend: the held instruction has not yet written NZCV
    typedef struct packed {
        ctrl_t               ctrl;
        logic                flag_pend;
        exe_cmd_e            cmd;
        logic [WORD_W-1:0]   pc;
        logic [WORD_W-1:0]   val_rn;
        logic [WORD_W-1:0]   val_rm;
        logic [IMM8_W-1:0]   imm_8;
        logic [ROT_W-1:0]    rotate_imm;
        logic [SIMM_W-1:0]   signed_imm;
        logic [REG_W-1:0]    dest;
    } id_exe_t;

    localparam id_exe_t ID_EXE_BUBBLE = '{ctrl: CTRL_BUBBLE, cmd: CMD_NOP, default: '0};

endpackage

// File: rtl/exe_stage_val2_gen.sv
// Shifter operand (Val2) generator, purely combinational.
//   val_rm       register operand to be shifted
//   imm_8        immediate byte / shift field (bit7 = amount lsb, [6:5] = type)
//   rotate_imm   immediate rotate / shift amount high nibble
//   is_immediate select rotated immediate
//   mem_access   select 12-bit load/store offset
//   val2_c       resulting second ALU operand
module exe_stage_val2_gen
    import exe_stage_pkg::*;
(
    input  logic [WORD_W-1:0] val_rm,
    input  logic [IMM8_W-1:0] imm_8,
    input  logic [ROT_W-1:0]  rotate_imm,
    input  logic              is_immediate,
    input  logic              mem_access,
    output logic [WORD_W-1:0] val2_c
);

    localparam int unsigned AMT_W = ROT_W + 1;

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x,
                                              input logic [AMT_W-1:0]  n);
        logic [2*WORD_W-1:0] dbl;
        dbl = {x, x} >> n;
        return dbl[WORD_W-1:0];
    endfunction

    logic [AMT_W-1:0] sh_amt_c;
    assign sh_amt_c = {rotate_imm, imm_8[IMM8_W-1]};

    // Immediate wins, then memory offset, then register shift
    always_comb begin
        val2_c = '0;
        if (is_immediate) begin
            val2_c = ror(WORD_W'(imm_8), {rotate_imm, 1'b0});
        end else if (mem_access) begin
            val2_c = WORD_W'({rotate_imm, imm_8});
        end else begin
            case (shift_e'(imm_8[6:5]))
                SH_LSL:  val2_c = val_rm << sh_amt_c;
                SH_LSR:  val2_c = val_rm >> sh_amt_c;
                SH_ASR:  val2_c = WORD_W'($signed(val_rm) >>> sh_amt_c);
                SH_ROR:  val2_c = ror(val_rm, sh_amt_c);
                default: val2_c = val_rm;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ID/EXE register, Val2, ALU, branch target and NZCV.
//   clk, rst            clock, asynchronous active-low reset
//   freeze              hold the ID/EXE register (hazard stall)
//   pc_in .. dest       decoded instruction bundle from decode
//   alu_result          ALU output of the registered instruction
//   st_val, dest_out    registered store data / destination
//   wb_en_out, mem_*    registered control
//   branch_taken        registered B, flush request to fetch/decode
//   branch_addr         pc + sign_extend(signed_imm) * 4
//   status_reg_out      NZCV at [FLAG_LSB+3:FLAG_LSB], zero elsewhere
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned FLAG_LSB = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [CMD_W-1:0]  exe_command,
    input  logic              wb_en,
    input  logic              mem_read_en,
    input  logic              mem_write_en,
    input  logic              S,
    input  logic              B,
    input  logic              is_immediate,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [IMM8_W-1:0] imm_8,
    input  logic [ROT_W-1:0]  rotate_imm,
    input  logic [SIMM_W-1:0] signed_imm,
    input  logic [REG_W-1:0]  dest,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] st_val,
    output logic [REG_W-1:0]  dest_out,
    output logic              wb_en_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr,
    output logic [DATA_W-1:0] status_reg_out
);

    id_exe_t           id_exe;
    id_exe_t           id_exe_nxt;
    logic [NZCV_W-1:0] nzcv;
    logic [NZCV_W-1:0] alu_flags_c;
    logic [DATA_W-1:0] val2_c;
    logic [DATA_W-1:0] alu_res_c;
    logic [DATA_W-1:0] add_b_c;
    logic [DATA_W:0]   sum_c;
    logic              add_cin_c;
    logic              c_c;
    logic              v_c;

    // ID/EXE next state: flush beats stall beats capture
    always_comb begin
        id_exe_nxt = id_exe;
        if (id_exe.ctrl.b) begin
            id_exe_nxt = ID_EXE_BUBBLE;
        end else if (freeze) begin
            id_exe_nxt.flag_pend = 1'b0;
        end else begin
            id_exe_nxt.ctrl       = '{wb_en: wb_en, mem_read: mem_read_en,
                                      mem_write: mem_write_en, s: S, b: B,
                                      is_imm: is_immediate};
            id_exe_nxt.flag_pend  = 1'b1;
            id_exe_nxt.cmd        = exe_cmd_e'(exe_command);
            id_exe_nxt.pc         = pc_in;
            id_exe_nxt.val_rn     = val_rn;
            id_exe_nxt.val_rm     = val_rm;
            id_exe_nxt.imm_8      = imm_8;
            id_exe_nxt.rotate_imm = rotate_imm;
            id_exe_nxt.signed_imm = signed_imm;
            id_exe_nxt.dest       = dest;
        end
    end

    // NZCV written once per captured S instruction, even while frozen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_exe <= ID_EXE_BUBBLE;
            nzcv   <= '0;
        end else begin
            if (id_exe.ctrl.s && id_exe.flag_pend) begin
                nzcv <= alu_flags_c;
            end
            id_exe <= id_exe_nxt;
        end
    end

    exe_stage_val2_gen u_val2_gen (
        .val_rm       (id_exe.val_rm),
        .imm_8        (id_exe.imm_8),
        .rotate_imm   (id_exe.rotate_imm),
        .is_immediate (id_exe.ctrl.is_imm),
        .mem_access   (id_exe.ctrl.mem_read | id_exe.ctrl.mem_write),
        .val2_c       (val2_c)
    );

    // Subtracts run through the adder as Rn + ~Val2 + cin, so C is NOT-borrow
    always_comb begin
        add_b_c   = val2_c;
        add_cin_c = 1'b0;
        case (id_exe.cmd)
            CMD_ADC: add_cin_c = nzcv[FLAG_C];
            CMD_SUB: begin
                add_b_c   = ~val2_c;
                add_cin_c = 1'b1;
            end
            CMD_SBC: begin
                add_b_c   = ~val2_c;
                add_cin_c = nzcv[FLAG_C];
            end
            default: ;
        endcase
        sum_c = {1'b0, id_exe.val_rn} + {1'b0, add_b_c} + {{DATA_W{1'b0}}, add_cin_c};

        alu_res_c = '0;
        c_c       = 1'b0;
        v_c       = 1'b0;
        case (id_exe.cmd)
            CMD_MOV: alu_res_c = val2_c;
            CMD_MVN: alu_res_c = ~val2_c;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                alu_res_c = sum_c[DATA_W-1:0];
                c_c       = sum_c[DATA_W];
                v_c       = (id_exe.val_rn[DATA_W-1] == add_b_c[DATA_W-1]) &&
                            (alu_res_c[DATA_W-1] != id_exe.val_rn[DATA_W-1]);
            end
            CMD_AND: alu_res_c = id_exe.val_rn & val2_c;
            CMD_ORR: alu_res_c = id_exe.val_rn | val2_c;
            CMD_EOR: alu_res_c = id_exe.val_rn ^ val2_c;
            default: alu_res_c = '0;
        endcase

        alu_flags_c         = '0;
        alu_flags_c[FLAG_N] = alu_res_c[DATA_W-1];
        alu_flags_c[FLAG_Z] = (alu_res_c == '0);
        alu_flags_c[FLAG_C] = c_c;
        alu_flags_c[FLAG_V] = v_c;
    end

    assign alu_result     = alu_res_c;
    assign st_val         = id_exe.val_rm;
    assign dest_out       = id_exe.dest;
    assign wb_en_out      = id_exe.ctrl.wb_en;
    assign mem_read_out   = id_exe.ctrl.mem_read;
    assign mem_write_out  = id_exe.ctrl.mem_write;
    assign branch_taken   = id_exe.ctrl.b;
    assign branch_addr    = id_exe.pc +
                            {{(DATA_W-SIMM_W-2){id_exe.signed_imm[SIMM_W-1]}},
                             id_exe.signed_imm, 2'b00};
    assign status_reg_out = DATA_W'(nzcv) << FLAG_LSB;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: a behavioural model predicts outputs at each
// clock edge and queues them; a negedge monitor pops and compares.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic [31:0] pc_in;
    logic [3:0]  exe_command;
    logic        wb_en, mem_read_en, mem_write_en, S, B, is_immediate;
    logic [31:0] val_rn, val_rm;
    logic [7:0]  imm_8;
    logic [3:0]  rotate_imm;
    logic [23:0] signed_imm;
    logic [3:0]  dest;
    logic [31:0] alu_result, st_val, branch_addr, status_reg_out;
    logic [3:0]  dest_out;
    logic        wb_en_out, mem_read_out, mem_write_out, branch_taken;

    exe_stage dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .pc_in          (pc_in),
        .exe_command    (exe_command),
        .wb_en          (wb_en),
        .mem_read_en    (mem_read_en),
        .mem_write_en   (mem_write_en),
        .S              (S),
        .B              (B),
        .is_immediate   (is_immediate),
        .val_rn         (val_rn),
        .val_rm         (val_rm),
        .imm_8          (imm_8),
        .rotate_imm     (rotate_imm),
        .signed_imm     (signed_imm),
        .dest           (dest),
        .alu_result     (alu_result),
        .st_val         (st_val),
        .dest_out       (dest_out),
        .wb_en_out      (wb_en_out),
        .mem_read_out   (mem_read_out),
        .mem_write_out  (mem_write_out),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .status_reg_out (status_reg_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  cmd;
        bit          wb, mr, mw, s, b, imm;
        logic [31:0] rn, rm;
        logic [7:0]  imm8;
        logic [3:0]  rot;
        logic [23:0] simm;
        logic [3:0]  dest;
        bit          done;   // flags already written for this instruction
    } instr_t;

    typedef struct {
        bit     freeze;
        instr_t ins;
    } stim_t;

    typedef struct {
        logic [31:0] alu, st_val, baddr, status;
        logic [3:0]  dest;
        bit          wb, mr, mw, bt;
    } exp_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    exp_t   exp_q[$];
    exp_t   mon_e;
    instr_t cur;
    logic [3:0] m_nzcv;   // {N,Z,C,V}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic instr_t bubble_i();
        instr_t i;
        i.pc = 0; i.cmd = 0; i.wb = 0; i.mr = 0; i.mw = 0; i.s = 0; i.b = 0; i.imm = 0;
        i.rn = 0; i.rm = 0; i.imm8 = 0; i.rot = 0; i.simm = 0; i.dest = 0; i.done = 0;
        return i;
    endfunction

    // Second operand from the architectural rules
    function automatic logic [31:0] m_val2(input instr_t i);
        longint unsigned x;
        int unsigned     n;
        int              sv;
        if (i.imm) begin
            x = 64'(i.imm8);
            n = 2 * i.rot;
        end else if (i.mr || i.mw) begin
            return {20'h0, i.rot, i.imm8};
        end else begin
            n = {i.rot, i.imm8[7]};
            x = 64'(i.rm);
            case (i.imm8[6:5])
                2'd0: return 32'(x << n);
                2'd1: return 32'(x >> n);
                2'd2: begin sv = i.rm; return 32'(sv >>> n); end
                default: ;
            endcase
        end
        if (n == 0) return 32'(x);
        return 32'((x >> n) | (x << (32 - n)));
    endfunction

    // ALU result and flags via wide integer arithmetic
    function automatic void m_alu(input instr_t i, input bit cin,
                                  output logic [31:0] r, output logic [3:0] f);
        logic [31:0] v2;
        longint a, b, sa, sb, full, sf;
        bit c, v, arith;
        v2 = m_val2(i);
        a = longint'({32'h0, i.rn});
        b = longint'({32'h0, v2});
        sa = longint'($signed(i.rn));
        sb = longint'($signed(v2));
        full = 0; sf = 0; c = 0; arith = 0;
        case (i.cmd)
            4'd1: full = b;
            4'd9: full = b ^ 64'hFFFF_FFFF;
            4'd2: begin full = a + b; sf = sa + sb; c = (full >>> 32) != 0; arith = 1; end
            4'd3: begin full = a + b + longint'(cin); sf = sa + sb + longint'(cin);
                        c = (full >>> 32) != 0; arith = 1; end
            4'd4: begin full = a - b; sf = sa - sb; c = full >= 0; arith = 1; end
            4'd5: begin full = a - b - longint'(!cin); sf = sa - sb - longint'(!cin);
                        c = full >= 0; arith = 1; end
            4'd6: full = a & b;
            4'd7: full = a | b;
            4'd8: full = a ^ b;
            default: full = 0;
        endcase
        v = arith && (sf > 64'sd2147483647 || sf < -64'sd2147483648);
        r = full[31:0];
        f = {r[31], r == 32'h0, c, v};
    endfunction

    function automatic void model_reset();
        cur    = bubble_i();
        m_nzcv = 4'h0;
    endfunction

    // One clock edge of the stage as seen by its users
    function automatic void model_edge(input stim_t st);
        logic [31:0] r;
        logic [3:0]  f;
        m_alu(cur, m_nzcv[1], r, f);
        if (cur.s && !cur.done) m_nzcv = f;
        if (cur.b) begin
            cur = bubble_i();
        end else if (st.freeze) begin
            cur.done = 1;
        end else begin
            cur      = st.ins;
            cur.done = 0;
        end
    endfunction

    function automatic exp_t m_expect();
        exp_t        e;
        logic [3:0]  f;
        int          off;
        m_alu(cur, m_nzcv[1], e.alu, f);
        off      = $signed(cur.simm);
        e.st_val = cur.rm;
        e.dest   = cur.dest;
        e.wb     = cur.wb;
        e.mr     = cur.mr;
        e.mw     = cur.mw;
        e.bt     = cur.b;
        e.baddr  = cur.pc + 32'(off * 4);
        e.status = {m_nzcv, 28'h0};
        return e;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0000;
            default: return $urandom();
        endcase
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.freeze     = ($urandom_range(0, 3) == 0);
        s.ins.pc     = $urandom();
        s.ins.cmd    = 4'($urandom_range(0, 15));
        s.ins.wb     = 1'($urandom_range(0, 1));
        s.ins.mr     = ($urandom_range(0, 7) == 0);
        s.ins.mw     = ($urandom_range(0, 7) == 0);
        s.ins.s      = 1'($urandom_range(0, 1));
        s.ins.b      = ($urandom_range(0, 9) == 0);
        s.ins.imm    = 1'($urandom_range(0, 1));
        s.ins.rn     = rand_word();
        s.ins.rm     = rand_word();
        s.ins.imm8   = 8'($urandom());
        s.ins.rot    = 4'($urandom());
        s.ins.simm   = 24'($urandom());
        s.ins.dest   = 4'($urandom());
        s.ins.done   = 0;
        return s;
    endfunction

    function automatic stim_t mk(input logic [3:0] cmd, input bit s, input bit imm,
                                 input logic [31:0] rn, input logic [31:0] rm,
                                 input logic [7:0] imm8, input logic [3:0] rot);
        stim_t st;
        st.freeze   = 0;
        st.ins      = bubble_i();
        st.ins.cmd  = cmd;
        st.ins.s    = s;
        st.ins.imm  = imm;
        st.ins.rn   = rn;
        st.ins.rm   = rm;
        st.ins.imm8 = imm8;
        st.ins.rot  = rot;
        return st;
    endfunction

    task automatic apply(input stim_t s);
        freeze       = s.freeze;
        pc_in        = s.ins.pc;
        exe_command  = s.ins.cmd;
        wb_en        = s.ins.wb;
        mem_read_en  = s.ins.mr;
        mem_write_en = s.ins.mw;
        S            = s.ins.s;
        B            = s.ins.b;
        is_immediate = s.ins.imm;
        val_rn       = s.ins.rn;
        val_rm       = s.ins.rm;
        imm_8        = s.ins.imm8;
        rotate_imm   = s.ins.rot;
        signed_imm   = s.ins.simm;
        dest         = s.ins.dest;
    endtask

    // Drive, cross one rising edge, queue the prediction; returns edge+1
    task automatic step(input stim_t s);
        apply(s);
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge(s);
        exp_q.push_back(m_expect());
        #1;
    endtask

    // Asynchronous reset between edges replaces the pending prediction
    task automatic assert_reset();
        rst = 1'b0;
        model_reset();
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(m_expect());
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("alu_result",     alu_result,     mon_e.alu);
            chk("st_val",         st_val,         mon_e.st_val);
            chk("dest_out",       32'(dest_out),  32'(mon_e.dest));
            chk("wb_en_out",      32'(wb_en_out), 32'(mon_e.wb));
            chk("mem_read_out",   32'(mem_read_out),  32'(mon_e.mr));
            chk("mem_write_out",  32'(mem_write_out), 32'(mon_e.mw));
            chk("branch_taken",   32'(branch_taken),  32'(mon_e.bt));
            chk("branch_addr",    branch_addr,    mon_e.baddr);
            chk("status_reg_out", status_reg_out, mon_e.status);
        end
    end

    initial begin
        stim_t st;

        // Reset held while inputs toggle
        rst = 1'b1;
        apply(mk(4'd0, 0, 0, 0, 0, 8'h0, 4'h0));
        #1 rst = 1'b0;
        #1;
        model_reset();
        chk("rst_alu",    alu_result,          32'h0);
        chk("rst_status", status_reg_out,      32'h0);
        chk("rst_baddr",  branch_addr,         32'h0);
        chk("rst_bt",     32'(branch_taken),   32'h0);
        chk("rst_wb",     32'(wb_en_out),      32'h0);
        repeat (4) step(rand_stim());
        rst = 1'b1;

        // ADD with overflow into N
        st = mk(4'd2, 1, 1, 32'h7FFF_FFFF, 32'h0, 8'h01, 4'h0);
        step(st);
        chk("add_ovf_result", alu_result, 32'h8000_0000);

        // Rotated immediate MOV, S=0
        st = mk(4'd1, 0, 1, 32'h0, 32'h0, 8'hFF, 4'h4);
        step(st);
        chk("mov_rot_result", alu_result, 32'hFF00_0000);
        chk("add_ovf_flags",  status_reg_out, 32'h9000_0000);

        // CMP with LSL #1 register operand
        st = mk(4'd4, 1, 0, 32'h5, 32'h3, 8'h80, 4'h0);
        step(st);
        chk("cmp_result",      alu_result, 32'hFFFF_FFFF);
        chk("mov_keeps_flags", status_reg_out, 32'h9000_0000);

        // Branch, then a frozen follower that must be flushed
        st = mk(4'd0, 0, 0, 32'h0, 32'h0, 8'h0, 4'h0);
        st.ins.pc = 32'h100; st.ins.simm = 24'hFF_FFFE; st.ins.b = 1;
        step(st);
        chk("br_taken", 32'(branch_taken), 32'h1);
        chk("br_addr",  branch_addr, 32'h0000_00F8);
        chk("cmp_flags", status_reg_out, 32'h8000_0000);
        st = mk(4'd2, 1, 1, 32'h1234, 32'h0, 8'h7, 4'h0);
        st.freeze = 1; st.ins.wb = 1; st.ins.dest = 4'h9;
        step(st);
        chk("br_bubble_bt", 32'(branch_taken), 32'h0);
        chk("br_bubble_wb", 32'(wb_en_out), 32'h0);
        chk("br_bubble_flags", status_reg_out, 32'h8000_0000);

        // Freeze holds result and destination
        st = mk(4'd2, 1, 1, 32'h10, 32'h0, 8'h20, 4'h0);
        st.ins.wb = 1; st.ins.dest = 4'h7;
        step(st);
        for (int k = 0; k < 3; k++) begin
            st = rand_stim();
            st.freeze = 1;
            step(st);
            chk("frz_alu",  alu_result, 32'h30);
            chk("frz_dest", 32'(dest_out), 32'h7);
        end

        // Frozen ADC: flags written exactly once
        st = mk(4'd3, 1, 1, 32'hFFFF_FFFF, 32'h0, 8'h01, 4'h0);
        step(st);
        chk("adc_first", alu_result, 32'h0);
        st = rand_stim(); st.freeze = 1; step(st);
        st = rand_stim(); st.freeze = 1; step(st);
        chk("adc_once_flags", status_reg_out, 32'h6000_0000);
        chk("adc_held_result", alu_result, 32'h1);

        // Random traffic with an asynchronous reset in the middle
        for (int k = 0; k < 200; k++) step(rand_stim());
        assert_reset();
        #1;
        chk("async_rst_status", status_reg_out, 32'h0);
        chk("async_rst_bt", 32'(branch_taken), 32'h0);
        repeat (2) step(rand_stim());
        rst = 1'b1;
        for (int k = 0; k < 200; k++) step(rand_stim());

        repeat (2) @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
